// File: rtl/nx_fetch_pkg.sv
// Shared types and sizing for the instruction-fetch arbiter slice.
// Grant encoding plus default RAM depth and the per-core region size derived from it.
package nx_fetch_pkg;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_LOAD,
        GRANT_CORE_0,
        GRANT_CORE_1
    } grant_e;

    localparam int NX_MAX_INSTRS   = 512;
    localparam int NX_ADDR_W       = $clog2(NX_MAX_INSTRS);
    localparam int NX_REGION_DEPTH = NX_MAX_INSTRS / 2;

    function automatic int region_depth(input int max_instrs);
        return max_instrs / 2;
    endfunction

endpackage

// File: rtl/nx_rr_arbiter_2.sv
// Two-requester round-robin arbiter; the last-grant register only advances when adv_i is high.
// The grant itself is combinational, so the caller can qualify or override it in the same cycle.
module nx_rr_arbiter_2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);

    // Set means requester 1 won most recently, so requester 0 wins the next tie.
    logic last_q;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else if (adv_i && (gnt_o != 2'b00)) begin
            last_q <= gnt_o[1];
        end
    end

endmodule

// File: rtl/nx_instr_fetch_arbiter.sv
// Shares one 1-cycle-latency instruction RAM between the loader (top priority) and two cores.
// Optional per-core stall counters are enabled by defining NX_FETCH_STALL_STATS_EN.
module nx_instr_fetch_arbiter
    import nx_fetch_pkg::*;
#(
    parameter int INSTR_WIDTH     = 15,
    parameter int MAX_INSTRS      = NX_MAX_INSTRS,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          store_core_i,
    input  logic [INSTR_WIDTH-1:0]        store_data_i,
    input  logic                          store_valid_i,
    output logic [$clog2(MAX_INSTRS)-1:0] core_0_populated_o,
    output logic [$clog2(MAX_INSTRS)-1:0] core_1_populated_o,
    input  logic [$clog2(MAX_INSTRS)-1:0] core_0_addr_i,
    input  logic                          core_0_rd_i,
    output logic [INSTR_WIDTH-1:0]        core_0_data_o,
    output logic                          core_0_stall_o,
    input  logic [$clog2(MAX_INSTRS)-1:0] core_1_addr_i,
    input  logic                          core_1_rd_i,
    output logic [INSTR_WIDTH-1:0]        core_1_data_o,
    output logic                          core_1_stall_o,
    output logic [$clog2(MAX_INSTRS)-1:0] ram_addr_o,
    output logic [INSTR_WIDTH-1:0]        ram_wr_data_o,
    output logic                          ram_wr_en_o,
    output logic                          ram_rd_en_o,
    input  logic [INSTR_WIDTH-1:0]        ram_rd_data_i,
    output logic                          overflow_o,
    output logic [STALL_CNT_WIDTH-1:0]    core_0_stalls_o,
    output logic [STALL_CNT_WIDTH-1:0]    core_1_stalls_o
);

    localparam int            AW     = $clog2(MAX_INSTRS);
    localparam logic [AW-1:0] REGION = AW'(region_depth(MAX_INSTRS));

    grant_e           grant;
    logic [1:0]       rr_gnt;
    logic [AW-1:0]    pop_0, pop_1, ld_pop;
    logic             ld_full;
    logic             vld_p1;
    logic             core_p1;
    logic [INSTR_WIDTH-1:0] data_0_p1, data_1_p1;
    logic             unused_addr_msb;

    assign unused_addr_msb = core_0_addr_i[AW-1] ^ core_1_addr_i[AW-1];

    // A load cycle must not consume a core's turn, so the rotation is frozen while loading.
    nx_rr_arbiter_2 u_rr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i ({core_1_rd_i, core_0_rd_i}),
        .adv_i (~store_valid_i),
        .gnt_o (rr_gnt)
    );

    assign ld_pop  = store_core_i ? pop_1 : pop_0;
    assign ld_full = (ld_pop == REGION);

    always_comb begin
        grant = GRANT_NONE;
        if (store_valid_i)  grant = GRANT_LOAD;
        else if (rr_gnt[0]) grant = GRANT_CORE_0;
        else if (rr_gnt[1]) grant = GRANT_CORE_1;
    end

    always_comb begin
        ram_addr_o    = '0;
        ram_wr_data_o = '0;
        ram_wr_en_o   = 1'b0;
        ram_rd_en_o   = 1'b0;
        case (grant)
            GRANT_LOAD: begin
                ram_addr_o    = {store_core_i, ld_pop[AW-2:0]};
                ram_wr_data_o = store_data_i;
                ram_wr_en_o   = ~ld_full;
            end
            GRANT_CORE_0: begin
                ram_addr_o  = {1'b0, core_0_addr_i[AW-2:0]};
                ram_rd_en_o = 1'b1;
            end
            GRANT_CORE_1: begin
                ram_addr_o  = {1'b1, core_1_addr_i[AW-2:0]};
                ram_rd_en_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign core_0_stall_o = core_0_rd_i & (grant != GRANT_CORE_0);
    assign core_1_stall_o = core_1_rd_i & (grant != GRANT_CORE_1);

    // Stage p0 -> p1: remember which core owns the read in flight, capture its word next edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pop_0      <= '0;
            pop_1      <= '0;
            overflow_o <= 1'b0;
            vld_p1     <= 1'b0;
            core_p1    <= 1'b0;
            data_0_p1  <= '0;
            data_1_p1  <= '0;
        end else begin
            if (store_valid_i) begin
                if (ld_full)           overflow_o <= 1'b1;
                else if (store_core_i) pop_1 <= pop_1 + AW'(1);
                else                   pop_0 <= pop_0 + AW'(1);
            end
            vld_p1  <= (grant == GRANT_CORE_0) || (grant == GRANT_CORE_1);
            core_p1 <= (grant == GRANT_CORE_1);
            if (vld_p1) begin
                if (core_p1) data_1_p1 <= ram_rd_data_i;
                else         data_0_p1 <= ram_rd_data_i;
            end
        end
    end

    assign core_0_populated_o = pop_0;
    assign core_1_populated_o = pop_1;
    assign core_0_data_o      = data_0_p1;
    assign core_1_data_o      = data_1_p1;

`ifdef NX_FETCH_STALL_STATS_EN
    logic [STALL_CNT_WIDTH-1:0] stalls_0, stalls_1;

    function automatic logic [STALL_CNT_WIDTH-1:0] sat_inc(input logic [STALL_CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + STALL_CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stalls_0 <= '0;
            stalls_1 <= '0;
        end else begin
            if (core_0_stall_o) stalls_0 <= sat_inc(stalls_0);
            if (core_1_stall_o) stalls_1 <= sat_inc(stalls_1);
        end
    end

    assign core_0_stalls_o = stalls_0;
    assign core_1_stalls_o = stalls_1;
`else
    assign core_0_stalls_o = '0;
    assign core_1_stalls_o = '0;
`endif

endmodule
